// File: rtl/multiplicador_defines.sv
// Shared encoding for the shift-add multiplier controller and datapath.
// Both blocks import it so they always agree on the state codes.
package multiplicador_defines;

    localparam int MULT_N  = 4;
    localparam int MULT_PW = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_BIT0 = 3'd1,
        ST_BIT1 = 3'd2,
        ST_BIT2 = 3'd3,
        ST_BIT3 = 3'd4,
        ST_END  = 3'd5
    } estado_mult_t;

endpackage

// File: rtl/multiplicador_ctrl.sv
// Sequencer for the shift-add multiplier: idle, four bit steps, then end.
// It stays in end while the start request is held so the result can be read.
module multiplicador_ctrl
    import multiplicador_defines::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         strt_cmpt_i,
    output estado_mult_t state_o
);

    estado_mult_t state_q;
    estado_mult_t state_d;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (strt_cmpt_i) state_d = ST_BIT0;
            ST_BIT0: state_d = ST_BIT1;
            ST_BIT1: state_d = ST_BIT2;
            ST_BIT2: state_d = ST_BIT3;
            ST_BIT3: state_d = ST_END;
            ST_END:  if (!strt_cmpt_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        state_o = state_q;
    end

endmodule

// File: rtl/multiplicador_top.sv
// Multiplier integration: controller sequencing the shift-add datapath.
module multiplicador_top
    import multiplicador_defines::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                strt_cmpt_i,
    input  logic [MULT_N-1:0]   a_i,
    input  logic [MULT_N-1:0]   b_i,
    output logic [MULT_PW-1:0]  product_o,
    output logic                done_o,
    output logic                busy_o
);

    estado_mult_t state;

    multiplicador_ctrl u_ctrl (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .strt_cmpt_i (strt_cmpt_i),
        .state_o     (state)
    );

    datapath_mult #(
        .N  (MULT_N),
        .PW (MULT_PW)
    ) u_dp (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .state_i   (state),
        .a_i       (a_i),
        .b_i       (b_i),
        .product_o (product_o),
        .done_o    (done_o),
        .busy_o    (busy_o)
    );

endmodule

// File: rtl/datapath_mult.sv
// Shift-add datapath driven by the controller's state code: latches operands
// in idle, performs one conditional add-and-shift per bit state.
module datapath_mult
    import multiplicador_defines::*;
#(
    parameter int N  = MULT_N,
    parameter int PW = MULT_PW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  estado_mult_t  state_i,
    input  logic [N-1:0]  a_i,
    input  logic [N-1:0]  b_i,
    output logic [PW-1:0] product_o,
    output logic          done_o,
    output logic          busy_o
);

    logic [PW-1:0] mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] product_q, product_d;
    logic          done_q, done_d;
    logic [PW-1:0] sum;

    // The bit-3 sum is also the final product, so it is computed once here.
    assign sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;
        done_d    = done_q;
        case (state_i)
            ST_BIT0, ST_BIT1, ST_BIT2: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
            end
            ST_BIT3: begin
                acc_d     = sum;
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                product_d = sum;
                done_d    = 1'b1;
            end
            ST_END: begin
            end
            default: begin
                mcand_d  = {{(PW-N){1'b0}}, a_i};
                mplier_d = b_i;
                acc_d    = '0;
                done_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign product_o = product_q;
    assign done_o    = done_q;
    assign busy_o    = state_i inside {ST_BIT0, ST_BIT1, ST_BIT2, ST_BIT3};

endmodule

// File: tb/tb_datapath_mult.sv
// Scoreboard bench for the shift-add datapath, standalone and behind the controller.
module tb_datapath_mult;
    import multiplicador_defines::*;

    logic         clk = 1'b0;
    logic         rst_i;
    estado_mult_t state_i;
    logic [3:0]   a_i, b_i;
    logic [7:0]   product_o;
    logic         done_o, busy_o;
    logic         strt_cmpt;
    logic [7:0]   top_product;
    logic         top_done, top_busy;

    int checks   = 0;
    int failures = 0;
    int expQ[$];

    always #5 clk = ~clk;

    datapath_mult dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .state_i   (state_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .product_o (product_o),
        .done_o    (done_o),
        .busy_o    (busy_o)
    );

    multiplicador_top u_top (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .strt_cmpt_i (strt_cmpt),
        .a_i         (a_i),
        .b_i         (b_i),
        .product_o   (top_product),
        .done_o      (top_done),
        .busy_o      (top_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle cycle with operands, four bit steps, then park in ST_END.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b);
        state_i = ST_IDLE;
        a_i = a;
        b_i = b;
        expQ.push_back(int'(a) * int'(b));
        tick();
        for (int s = 1; s <= 4; s++) begin
            state_i = estado_mult_t'(s[2:0]);
            tick();
        end
        state_i = ST_END;
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] expv;
        rst_i = 1'b0;
        tick();
        tick();
        checks++;
        if (product_o !== 8'd0 || done_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_initial product=%0d done=%b required product=0 done=0", product_o, done_o);
        end
        rst_i = 1'b1;
        run_op(4'd13, 4'd11);
        expv = 8'(expQ.pop_front());
        checks++;
        if (product_o !== expv || done_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_prior product=%0d done=%b required product=%0d done=1", product_o, done_o, expv);
        end
        rst_i = 1'b0;
        tick();
        tick();
        checks++;
        if (product_o !== 8'd0 || done_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_clears product=%0d done=%b required product=0 done=0", product_o, done_o);
        end
        rst_i = 1'b1;
    endtask

    task automatic test_busy();
        logic expBusy;
        for (int c = 0; c < 8; c++) begin
            state_i = estado_mult_t'(c[2:0]);
            #1;
            expBusy = (c >= 1 && c <= 4);
            checks++;
            if (busy_o !== expBusy) begin
                failures++;
                $display("[TB] FAIL busy code=%0d busy=%b required=%b", c, busy_o, expBusy);
            end
        end
        state_i = ST_IDLE;
        tick();
    endtask

    task automatic test_corners();
        logic [3:0] ta[5] = '{4'd15, 4'd0, 4'd9, 4'd1, 4'd8};
        logic [3:0] tb[5] = '{4'd15, 4'd9, 4'd0, 4'd1, 4'd8};
        logic [7:0] expv;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i]);
            expv = 8'(expQ.pop_front());
            checks++;
            if (product_o !== expv || done_o !== 1'b1) begin
                failures++;
                $display("[TB] FAIL corner %0d*%0d product=%0d done=%b required product=%0d done=1",
                         ta[i], tb[i], product_o, done_o, expv);
            end
        end
    endtask

    task automatic test_done_duration();
        logic [7:0] expv;
        run_op(4'd6, 4'd7);
        expv = 8'(expQ.pop_front());
        tick();
        tick();
        checks++;
        if (product_o !== expv || done_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL done_end_hold product=%0d done=%b required product=%0d done=1", product_o, done_o, expv);
        end
        state_i = ST_IDLE;
        #1;
        checks++;
        if (done_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL done_first_idle done=%b required=1", done_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || product_o !== expv) begin
            failures++;
            $display("[TB] FAIL done_cleared product=%0d done=%b required product=%0d done=0", product_o, done_o, expv);
        end
    endtask

    task automatic test_operand_change();
        logic [7:0] expv;
        state_i = ST_IDLE;
        a_i = 4'd13;
        b_i = 4'd11;
        expQ.push_back(143);
        tick();
        state_i = ST_BIT0;
        tick();
        state_i = ST_BIT1;
        a_i = 4'd2;
        b_i = 4'd2;
        tick();
        state_i = ST_BIT2;
        tick();
        state_i = ST_BIT3;
        tick();
        state_i = ST_END;
        #1;
        expv = 8'(expQ.pop_front());
        checks++;
        if (product_o !== expv) begin
            failures++;
            $display("[TB] FAIL operand_change product=%0d required=%0d", product_o, expv);
        end
    endtask

    task automatic test_midrun_reset();
        logic [7:0] expv;
        state_i = ST_IDLE;
        a_i = 4'd13;
        b_i = 4'd11;
        tick();
        state_i = ST_BIT0;
        tick();
        state_i = ST_BIT1;
        tick();
        state_i = ST_BIT2;
        rst_i = 1'b0;
        tick();
        checks++;
        if (product_o !== 8'd0 || done_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrun_reset product=%0d done=%b required product=0 done=0", product_o, done_o);
        end
        rst_i = 1'b1;
        run_op(4'd7, 4'd6);
        expv = 8'(expQ.pop_front());
        checks++;
        if (product_o !== expv) begin
            failures++;
            $display("[TB] FAIL after_reset_run product=%0d required=%0d", product_o, expv);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] expv;
        run_op(4'd5, 4'd5);
        expv = 8'(expQ.pop_front());
        tick();
        state_i = ST_IDLE;
        a_i = 4'd3;
        b_i = 4'd3;
        expQ.push_back(9);
        tick();
        for (int s = 1; s <= 3; s++) begin
            state_i = estado_mult_t'(s[2:0]);
            tick();
            checks++;
            if (product_o !== expv) begin
                failures++;
                $display("[TB] FAIL b2b_old_visible step=%0d product=%0d required=%0d", s, product_o, expv);
            end
        end
        state_i = ST_BIT3;
        tick();
        state_i = ST_END;
        #1;
        expv = 8'(expQ.pop_front());
        checks++;
        if (product_o !== expv || done_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_new product=%0d done=%b required product=%0d done=1", product_o, done_o, expv);
        end
    endtask

    task automatic test_invalid_state();
        logic [7:0] expv;
        logic [7:0] prev;
        run_op(4'd2, 4'd2);
        prev = 8'(expQ.pop_front());
        state_i = estado_mult_t'(3'd6);
        a_i = 4'd3;
        b_i = 4'd5;
        expQ.push_back(15);
        tick();
        checks++;
        if (done_o !== 1'b0 || product_o !== prev) begin
            failures++;
            $display("[TB] FAIL invalid_as_idle product=%0d done=%b required product=%0d done=0", product_o, done_o, prev);
        end
        a_i = 4'd0;
        b_i = 4'd0;
        for (int s = 1; s <= 4; s++) begin
            state_i = estado_mult_t'(s[2:0]);
            tick();
        end
        state_i = ST_END;
        #1;
        expv = 8'(expQ.pop_front());
        checks++;
        if (product_o !== expv) begin
            failures++;
            $display("[TB] FAIL invalid_relatch product=%0d required=%0d", product_o, expv);
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] expv;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(a[3:0], b[3:0]);
                expv = 8'(expQ.pop_front());
                checks++;
                if (product_o !== expv) begin
                    failures++;
                    $display("[TB] FAIL exhaustive %0d*%0d product=%0d required=%0d", a, b, product_o, expv);
                end
            end
        end
    endtask

    task automatic test_integration();
        logic [7:0] expv;
        int edges;
        state_i = ST_IDLE;
        a_i = 4'd12;
        b_i = 4'd10;
        strt_cmpt = 1'b1;
        expQ.push_back(120);
        edges = 0;
        while (top_done !== 1'b1 && edges < 20) begin
            tick();
            edges++;
        end
        a_i = 4'd1;
        b_i = 4'd1;
        expv = 8'(expQ.pop_front());
        checks++;
        if (edges != 5) begin
            failures++;
            $display("[TB] FAIL top_latency edges=%0d required=5", edges);
        end
        checks++;
        if (top_product !== expv) begin
            failures++;
            $display("[TB] FAIL top_product product=%0d required=%0d", top_product, expv);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (top_product !== expv || top_done !== 1'b1 || top_busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL top_hold cycle=%0d product=%0d done=%b busy=%b required product=%0d done=1 busy=0",
                         i, top_product, top_done, top_busy, expv);
            end
        end
        strt_cmpt = 1'b0;
        tick();
        tick();
        checks++;
        if (top_done !== 1'b0 || top_product !== expv) begin
            failures++;
            $display("[TB] FAIL top_return_idle product=%0d done=%b required product=%0d done=0", top_product, top_done, expv);
        end
    endtask

    initial begin
        rst_i     = 1'b0;
        state_i   = ST_IDLE;
        a_i       = 4'd0;
        b_i       = 4'd0;
        strt_cmpt = 1'b0;
        #2;
        test_reset();
        test_busy();
        test_corners();
        test_done_duration();
        test_operand_change();
        test_midrun_reset();
        test_back_to_back();
        test_invalid_state();
        test_exhaustive();
        test_integration();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
